// File: rtl/jk_bank_arbiter_if.sv
// Requester/bank-side bundle for jk_bank_arbiter: request, opcode and mask inputs,
// the bank feedback, and the J/K drive, acknowledge and read-back outputs.
interface jk_bank_arbiter_if #(parameter int WIDTH = 4);
    logic [3:0]         req;
    logic [7:0]         op;
    logic [4*WIDTH-1:0] mask;
    logic [WIDTH-1:0]   q;
    logic [WIDTH-1:0]   j;
    logic [WIDTH-1:0]   k;
    logic [3:0]         ack;
    logic [1:0]         gnt_id;
    logic               busy;
    logic [WIDTH-1:0]   rdata;

    modport master (
        output req, op, mask, q,
        input  j, k, ack, gnt_id, busy, rdata
    );

    modport slave (
        input  req, op, mask, q,
        output j, k, ack, gnt_id, busy, rdata
    );
endinterface

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter serialising read/clear/set/toggle commands from four requesters
// onto a shared JK flip-flop bank; one DRIVE cycle per operation, then an ack with read-back.
module jk_bank_arbiter #(
    parameter int WIDTH = 4
) (
    input logic           clk,
    input logic           rst,
    jk_bank_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

    state_t           state, state_next;
    logic [1:0]       ptr;
    logic [1:0]       gnt;
    logic [1:0]       gnt_next;
    logic             grant;
    logic [1:0]       op_l;
    logic [1:0]       op_sel;
    logic [WIDTH-1:0] mask_l;
    logic [WIDTH-1:0] mask_sel;
    logic [WIDTH-1:0] rdata_r;
    logic [WIDTH-1:0] j_d;
    logic [WIDTH-1:0] k_d;

    // First asserted request at or above ptr; the 2-bit add wraps mod 4.
    always_comb begin
        grant    = 1'b0;
        gnt_next = ptr;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!grant && bus.req[ptr + 2'(i)]) begin
                grant    = 1'b1;
                gnt_next = ptr + 2'(i);
            end
        end
    end

    always_comb begin
        op_sel   = '0;
        mask_sel = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (gnt_next == 2'(i)) begin
                op_sel   = bus.op[2*i +: 2];
                mask_sel = bus.mask[WIDTH*i +: WIDTH];
            end
        end
    end

    always_comb begin
        state_next = state;
        j_d        = '0;
        k_d        = '0;
        case (state)
            IDLE:  if (grant) state_next = DRIVE;
            DRIVE: begin
                state_next = DONE;
                case (op_l)
                    2'b01:   k_d = mask_l;
                    2'b10:   j_d = mask_l;
                    2'b11: begin
                        j_d = mask_l;
                        k_d = mask_l;
                    end
                    default: ;
                endcase
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            gnt     <= '0;
            op_l    <= '0;
            mask_l  <= '0;
            rdata_r <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && grant) begin
                gnt    <= gnt_next;
                ptr    <= gnt_next + 2'd1;
                op_l   <= op_sel;
                mask_l <= mask_sel;
            end
            // Same JK equation the bank applies at this edge.
            if (state == DRIVE)
                rdata_r <= (j_d & ~bus.q) | (~k_d & bus.q);
        end
    end

    assign bus.j      = j_d;
    assign bus.k      = k_d;
    assign bus.ack    = (state == DONE) ? (4'b0001 << gnt) : 4'b0000;
    assign bus.gnt_id = gnt;
    assign bus.busy   = (state != IDLE);
    assign bus.rdata  = rdata_r;
endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Randomized bench for jk_bank_arbiter: a transaction-level model plus a JK bank model,
// checked every cycle, with directed scenarios pinned by literal expectations.
module tb_jk_bank_arbiter;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jk_bank_arbiter_if #(.WIDTH(W)) bus ();
    jk_bank_arbiter #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // External JK flip-flop bank with a test-side load port.
    logic [W-1:0] bank;
    logic         bank_ld = 1'b1;
    logic [W-1:0] bank_val = '0;
    always @(posedge clk) begin
        if (bank_ld) bank <= bank_val;
        else         bank <= (bus.j & ~bank) | (~bus.k & bank);
    end
    assign bus.q = bank;

    function automatic logic [W-1:0] apply_op(input logic [1:0] o, input logic [W-1:0] m,
                                              input logic [W-1:0] q);
        case (o)
            2'd0:    return q;
            2'd1:    return q & ~m;
            2'd2:    return q | m;
            default: return q ^ m;
        endcase
    endfunction

    function automatic logic [2*W-1:0] jk_of(input logic [1:0] o, input logic [W-1:0] m);
        logic [W-1:0] z;
        z = '0;
        case (o)
            2'd0:    return {z, z};
            2'd1:    return {z, m};
            2'd2:    return {m, z};
            default: return {m, m};
        endcase
    endfunction

    // Model: a grant taken at edge g makes the next cycle DRIVE and the one after DONE.
    logic [1:0]   m_ptr, m_gnt, m_op;
    logic [W-1:0] m_mask;
    bit           m_active = 0;
    bit           m_valid = 0;
    int unsigned  t = 0;
    int unsigned  g_edge = 0;
    logic [W-1:0] e_j, e_k, e_rdata;
    logic [3:0]   e_ack;
    logic         e_busy;

    always @(posedge clk) begin
        t++;
        if (rst) begin
            m_active = 0;
            m_ptr    = 2'd0;
            m_gnt    = 2'd0;
            e_rdata  = '0;
            m_valid  = 1;
        end else if (m_valid) begin
            if (m_active && t == g_edge + 1)
                e_rdata = apply_op(m_op, m_mask, bank);
            if (m_active && t == g_edge + 2) begin
                m_active = 0;
            end else if (!m_active && bus.req != 4'b0000) begin
                for (int i = 0; i < 4; i++) begin
                    int w;
                    w = (int'(m_ptr) + i) % 4;
                    if (!m_active && bus.req[w]) begin
                        m_active = 1;
                        g_edge   = t;
                        m_gnt    = 2'(w);
                        m_ptr    = 2'((w + 1) % 4);
                        m_op     = bus.op[2*w +: 2];
                        m_mask   = bus.mask[W*w +: W];
                    end
                end
            end
        end
        e_j    = '0;
        e_k    = '0;
        e_ack  = '0;
        e_busy = 1'b0;
        if (m_active && t == g_edge) begin
            e_busy     = 1'b1;
            {e_j, e_k} = jk_of(m_op, m_mask);
        end
        if (m_active && t == g_edge + 1) begin
            e_busy = 1'b1;
            e_ack  = 4'(1 << m_gnt);
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_j", 32'(bus.j), 32'(e_j));
            check("model_k", 32'(bus.k), 32'(e_k));
            check("model_ack", 32'(bus.ack), 32'(e_ack));
            check("model_busy", 32'(bus.busy), 32'(e_busy));
            check("model_gnt_id", 32'(bus.gnt_id), 32'(m_gnt));
            check("model_rdata", 32'(bus.rdata), 32'(e_rdata));
        end
    end

    int order [10] = '{0, 1, 2, 3, 0, 1, 2, 3, 1, 3};

    initial begin
        bus.req  = '0;
        bus.op   = '0;
        bus.mask = '0;

        // Reset held with every requester asking
        @(negedge clk);
        bus.req = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        check("rst_j", 32'(bus.j), 0);
        check("rst_k", 32'(bus.k), 0);
        check("rst_ack", 32'(bus.ack), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_rdata", 32'(bus.rdata), 0);
        check("rst_gnt_id", 32'(bus.gnt_id), 0);
        rst     = 1'b0;
        bank_ld = 1'b0;

        // Round robin with all reads, then 1010 after requester 2's grant
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            check("rr_gnt_id", 32'(bus.gnt_id), 32'(order[n]));
            check("rr_busy", 32'(bus.busy), 1);
            @(negedge clk);
            check("rr_ack", 32'(bus.ack), 32'(1) << order[n]);
            @(negedge clk);
            if (n == 6) bus.req = 4'b1010;
        end
        bus.req = '0;

        // Set
        bank_ld  = 1'b1;
        bank_val = 4'b0000;
        @(negedge clk);
        bank_ld  = 1'b0;
        bus.req  = 4'b0001;
        bus.op   = 8'b00_00_00_10;
        bus.mask = 16'h0005;
        @(negedge clk);
        check("set_j", 32'(bus.j), 32'h5);
        check("set_k", 32'(bus.k), 32'h0);
        @(negedge clk);
        check("set_ack", 32'(bus.ack), 32'h1);
        check("set_rdata", 32'(bus.rdata), 32'h5);
        check("set_busy", 32'(bus.busy), 1);
        bus.req = '0;
        @(negedge clk);
        check("set_idle_busy", 32'(bus.busy), 0);

        // Toggle on bank 0101
        bus.req  = 4'b0100;
        bus.op   = 8'b00_11_00_00;
        bus.mask = 16'h0F00;
        @(negedge clk);
        check("tog_j", 32'(bus.j), 32'hF);
        check("tog_k", 32'(bus.k), 32'hF);
        @(negedge clk);
        check("tog_ack", 32'(bus.ack), 32'h4);
        check("tog_rdata", 32'(bus.rdata), 32'hA);
        bus.req  = '0;
        bank_ld  = 1'b1;
        bank_val = 4'b1111;
        @(negedge clk);

        // Clear on bank 1111
        bank_ld  = 1'b0;
        bus.req  = 4'b0010;
        bus.op   = 8'b00_00_01_00;
        bus.mask = 16'h0030;
        @(negedge clk);
        check("clr_j", 32'(bus.j), 32'h0);
        check("clr_k", 32'(bus.k), 32'h3);
        @(negedge clk);
        check("clr_ack", 32'(bus.ack), 32'h2);
        check("clr_rdata", 32'(bus.rdata), 32'hC);
        bus.req = '0;
        @(negedge clk);

        // Reset during DRIVE of a set
        bus.req  = 4'b0001;
        bus.op   = 8'b00_00_00_10;
        bus.mask = 16'h000F;
        @(negedge clk);
        check("rmid_drive_j", 32'(bus.j), 32'hF);
        rst = 1'b1;
        @(negedge clk);
        check("rmid_busy", 32'(bus.busy), 0);
        check("rmid_j", 32'(bus.j), 0);
        check("rmid_k", 32'(bus.k), 0);
        check("rmid_ack", 32'(bus.ack), 0);
        check("rmid_gnt_id", 32'(bus.gnt_id), 0);
        rst     = 1'b0;
        bus.req = 4'b1001;
        bus.op  = '0;
        @(negedge clk);
        check("rmid_ptr_gnt", 32'(bus.gnt_id), 0);
        @(negedge clk);
        check("rmid_ptr_ack", 32'(bus.ack), 32'h1);
        bus.req = '0;
        @(negedge clk);

        // Requester 3 withdraws and changes its mask during DRIVE
        bank_ld  = 1'b1;
        bank_val = 4'b0000;
        bus.req  = 4'b1000;
        bus.op   = 8'b10_00_00_00;
        bus.mask = 16'h3000;
        @(negedge clk);
        bank_ld = 1'b0;
        check("wd_j", 32'(bus.j), 32'h3);
        bus.req  = '0;
        bus.mask = 16'hC000;
        #1;
        check("wd_j_hold", 32'(bus.j), 32'h3);
        check("wd_k_hold", 32'(bus.k), 32'h0);
        @(negedge clk);
        check("wd_ack", 32'(bus.ack), 32'h8);
        check("wd_rdata", 32'(bus.rdata), 32'h3);
        @(negedge clk);

        // Randomized traffic with occasional resets and bank loads
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 99) == 0);
            for (int r = 0; r < 4; r++) begin
                if (bus.ack[r])
                    bus.req[r] = ($urandom_range(0, 1) == 1);
                else if (!bus.req[r])
                    bus.req[r] = ($urandom_range(0, 2) == 0);
                else if ($urandom_range(0, 15) == 0)
                    bus.req[r] = 1'b0;
            end
            bus.op   = 8'($urandom);
            bus.mask = 16'($urandom);
            bank_ld  = ($urandom_range(0, 19) == 0);
            bank_val = W'($urandom);
        end
        @(negedge clk);
        rst     = 1'b0;
        bank_ld = 1'b0;
        bus.req = '0;
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/jk_bank_arbiter.md
# jk_bank_arbiter

Round-robin command arbiter for a shared bank of JK flip-flops. Four requesters each issue one of: read, clear bits, set bits or toggle bits, applied to a masked subset of the bank. The block serialises the requests, drives the bank's J/K inputs for exactly one clock per operation, and returns an acknowledge with the bank's post-operation value. It sits between the requester logic and the JK flip-flop bank; the bank itself, including its own reset, is outside this block.

## Interface
- WIDTH, 4, number of JK flip-flops in the bank (1..16)
- Clock  in  1  single clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high
- req  in  4  request per requester; bit i = requester i
- op  in  8  2-bit opcode per requester, op[2i+1:2i]: 00 read, 01 clear, 10 set, 11 toggle
- mask  in  4*WIDTH  per-requester bit mask, mask[WIDTH*i +: WIDTH]
- Q  in  WIDTH  current bank state, fed back from the flip-flops
- J  out  WIDTH  bank J inputs
- K  out  WIDTH  bank K inputs
- ack  out  4  one-hot, one-cycle completion pulse
- gnt_id  out  2  index of the current grantee
- busy  out  1  high in DRIVE and DONE
- rdata  out  WIDTH  bank value after the acknowledged operation

## Operation
- The FSM has three states: IDLE, DRIVE and DONE.
- **IDLE**
  - If req is nonzero, grant the first asserted requester, searching upward from round-robin pointer ptr with mod-4 wrap.
  - Latch its op and mask, set gnt_id, set ptr <= grantee+1 mod 4, and go to DRIVE.
  - If req is zero, stay in IDLE; ptr is unchanged.
- **DRIVE** (exactly one cycle)
  - J and K are driven from the latched op and mask:
    - read: J=0, K=0
    - clear: J=0, K=mask
    - set: J=mask, K=0
    - toggle: J=mask, K=mask
  - At the edge ending DRIVE, rdata <= (J & ~Q) | (~K & Q). This is the value the bank takes at that same edge.
  - Go to DONE.
- **DONE** (exactly one cycle)
  - J=K=0 and ack[gnt_id]=1.
  - Go to IDLE.
- J and K are zero in every state except DRIVE.
- The latched op and mask are used throughout the operation. Changing req, op or mask after the grant has no effect on it.
- A requester that drops req during DRIVE still receives its ack.
- Requester protocol:
  - A requester holds req until it sees ack.
  - If req is still high in the IDLE cycle after DONE, it is a new request and is arbitrated normally.
- Bits outside mask are never disturbed; their J and K are both 0.
- Reset, synchronous, has priority over everything else:
  - state=IDLE, ptr=0, J=K=0, ack=0, gnt_id=0, busy=0, rdata=0.
  - If Reset is asserted in DRIVE or DONE, the operation is abandoned and no ack is issued.
  - The bank may already have been updated if the DRIVE edge occurred.

## Timing
- Requests are sampled at edge n in IDLE. J and K are valid during cycle n+1 (DRIVE). ack and rdata are valid during cycle n+2 (DONE).
- Maximum throughput is one operation per 3 cycles.
- gnt_id is valid from DRIVE through DONE and holds its value in IDLE.
- rdata holds until the next DRIVE edge.
- Worst-case wait for a continuously requesting requester is 3 other operations, i.e. 9 cycles before its DRIVE.
- All outputs are registered or decoded from registered state only. There is no combinational path from req, op or mask to any output.

## Test plan
- **Reset:** assert Reset for 2 cycles with req=1111 -> J=0000, K=0000, ack=0000, busy=0, rdata=0000, gnt_id=0; the first grant after release goes to requester 0.
- **Set:** req=0001, op0=10, mask0=0101, Q=0000 -> DRIVE: J=0101, K=0000; DONE: ack=0001, rdata=0101, busy=1; IDLE next cycle.
- **Toggle and clear:**
  - req=0100, op2=11, mask2=1111, Q=0101 -> J=K=1111, rdata=1010, ack=0100.
  - Then req=0010, op1=01, mask1=0011, Q=1111 -> J=0000, K=0011, rdata=1100.
- **Round-robin fairness:** req=1111 held, all ops read -> grant order 0,1,2,3,0 with ack pulses every 3 cycles. Then req=1010 after requester 2 was granted -> grant order 3,1,3.
- **Reset mid-operation:** assert Reset in the DRIVE cycle of a set -> next cycle IDLE, J=K=0, no ack, ptr=0.
- **Request withdrawal:** requester 3 drops req in DRIVE -> ack=1000 still pulses in DONE. Changing mask3 during DRIVE does not change J or K.
